// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: branch-mode encodings and select width.
// Used by pc_unit and pc_ras; the return-address stack is enabled with PC_RAS_EN.
package pc_unit_pkg;

    localparam int PC_IMR_SEL_W = 2;

    typedef enum logic [PC_IMR_SEL_W-1:0] {
        PC_REL  = 2'd0,
        PC_REG  = 2'd1,
        PC_CALL = 2'd2,
        PC_RET  = 2'd3
    } pc_mode_e;

    // Width needed to hold a stack occupancy of 0..depth inclusive.
    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
// A pop from an empty stack is ignored. Both cases set the sticky err flag.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = ras_cnt_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_next_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              err_r;
    logic              err_next_s;
    logic              full_s;
    logic              empty_s;

    assign full_s  = (count_r == CNT_MAX);
    assign empty_s = (count_r == CNT_ZERO);

    // Next pointer, occupancy and error flag; ptr_r always addresses the next free slot.
    always_comb begin
        ptr_next_s   = ptr_r;
        count_next_s = count_r;
        err_next_s   = err_r;
        if (push) begin
            ptr_next_s = ptr_r + PTR_ONE;
            if (full_s) begin
                err_next_s = 1'b1;
            end else begin
                count_next_s = count_r + CNT_ONE;
            end
        end else if (pop) begin
            if (empty_s) begin
                err_next_s = 1'b1;
            end else begin
                ptr_next_s   = ptr_r - PTR_ONE;
                count_next_s = count_r - CNT_ONE;
            end
        end else begin
            err_next_s = err_r;
        end
    end

    // Pointer, count and sticky error state.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            ptr_r   <= PTR_ZERO;
            count_r <= CNT_ZERO;
            err_r   <= 1'b0;
        end else begin
            ptr_r   <= ptr_next_s;
            count_r <= count_next_s;
            err_r   <= err_next_s;
        end
    end

    // Entry storage; never read while empty, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[ptr_r] <= push_data;
        end
    end

    assign top   = mem_r[ptr_r - PTR_ONE];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign err   = err_r;

endmodule

// File: rtl/pc_unit.sv
// Program counter with relative/register branches and optional call/return stack.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL acts as REL and RET as REG.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    n_rst,
    input  logic                    stall,
    input  logic                    bre,
    input  logic [PC_IMR_SEL_W-1:0] imr_sel,
    input  logic [DATA_W-1:0]       imm,
    input  logic [DATA_W-1:0]       rs,
    output logic [DATA_W-1:0]       out,
    output logic                    ras_empty,
    output logic                    ras_full,
    output logic                    ras_err
);

    localparam logic [DATA_W-1:0] PC_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] PC_ONE  = DATA_W'(1);

    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] pc_next_s;
    logic [DATA_W-1:0] seq_s;
    logic [DATA_W-1:0] rel_s;

    // Both targets are "+1" relative to the current PC; the adders wrap naturally.
    assign seq_s = pc_r + PC_ONE;
    assign rel_s = pc_r + imm + PC_ONE;

`ifdef PC_RAS_EN
    localparam int CNT_W = ras_cnt_w(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] ras_top_s;
    logic [CNT_W-1:0]  ras_count_s;
    logic              ras_full_s;
    logic              ras_empty_s;
    logic              ras_err_s;

    // Next PC and stack requests; stall suppresses both so nothing moves.
    always_comb begin
        pc_next_s = seq_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        if (stall) begin
            pc_next_s = pc_r;
        end else if (bre) begin
            case (pc_mode_e'(imr_sel))
                PC_REL:  pc_next_s = rel_s;
                PC_REG:  pc_next_s = rs;
                PC_CALL: begin
                    pc_next_s = rel_s;
                    push_s    = 1'b1;
                end
                PC_RET: begin
                    pop_s = 1'b1;
                    if (ras_count_s != CNT_ZERO) begin
                        pc_next_s = ras_top_s;
                    end else begin
                        pc_next_s = seq_s;
                    end
                end
                default: pc_next_s = seq_s;
            endcase
        end else begin
            pc_next_s = seq_s;
        end
    end

    pc_ras #(
        .DATA_W (DATA_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .n_rst     (n_rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (seq_s),
        .top       (ras_top_s),
        .count     (ras_count_s),
        .full      (ras_full_s),
        .empty     (ras_empty_s),
        .err       (ras_err_s)
    );

    assign ras_empty = ras_empty_s;
    assign ras_full  = ras_full_s;
    assign ras_err   = ras_err_s;
`else
    // Next PC without a stack: CALL degrades to REL, RET to REG.
    always_comb begin
        pc_next_s = seq_s;
        if (stall) begin
            pc_next_s = pc_r;
        end else if (bre) begin
            case (pc_mode_e'(imr_sel))
                PC_REL:  pc_next_s = rel_s;
                PC_REG:  pc_next_s = rs;
                PC_CALL: pc_next_s = rel_s;
                PC_RET:  pc_next_s = rs;
                default: pc_next_s = seq_s;
            endcase
        end else begin
            pc_next_s = seq_s;
        end
    end

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    // PC register; the only path to out.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            pc_r <= PC_ZERO;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign out = pc_r;

endmodule
